// File: rtl/add_resp.sv
//------------------------------------------------------------------------------
// Module      : add_resp
// Description : Handshaked 4-bit adder responder. It registers each accepted
//               a+b into a small in-order result FIFO. Optional macro
//               ADD_OVF_CNT_EN adds a saturating carry-out counter (ovf_cnt).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module add_resp #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
`ifdef ADD_OVF_CNT_EN
    ,
    output logic [CNT_W-1:0] ovf_cnt
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_BITS = $clog2(DEPTH + 1);
    localparam logic [CNT_BITS-1:0] c_DEPTH    = CNT_BITS'(DEPTH);
    localparam logic [PTR_W-1:0]    c_LAST_PTR = PTR_W'(DEPTH - 1);

    generate
        if (DEPTH < 1 || CNT_W < 1) begin : g_bad_params
            $error("add_resp: DEPTH and CNT_W must be >= 1");
        end
    endgenerate

    logic [WIDTH:0]      r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_BITS-1:0] r_count;

    logic                w_push;
    logic                w_pop;
    logic [WIDTH:0]      w_sum;

    assign w_sum     = {1'b0, a} + {1'b0, b};
    assign out_valid = (r_count != '0);
    // A pop at full frees a slot for a push in the same cycle.
    assign in_ready  = (r_count < c_DEPTH) || out_ready;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign sum       = out_valid ? r_mem[r_rd_ptr] : '0;

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef ADD_OVF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (w_push && w_sum[WIDTH] && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_add_resp.sv
//------------------------------------------------------------------------------
// Module      : tb_add_resp
// Description : Self-checking bench for add_resp (vector table, directed
//               corner sequences, randomized run against a queue model).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_add_resp;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;
    localparam int CNT_W = 2;
    localparam int OVF_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;
`ifdef ADD_OVF_CNT_EN
    logic [CNT_W-1:0] ovf_cnt;
`endif

    int n_checks;
    int n_fail;

    add_resp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum)
`ifdef ADD_OVF_CNT_EN
        ,
        .ovf_cnt   (ovf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] va;
        logic [WIDTH-1:0] vb;
        logic [WIDTH:0]   exp_sum;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_ovf(input string name, input int exp);
`ifdef ADD_OVF_CNT_EN
        check(name, 32'(ovf_cnt), 32'(exp));
`endif
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int va, input int vb, input logic r);
        in_valid  = v;
        a         = WIDTH'(va);
        b         = WIDTH'(vb);
        out_ready = r;
    endtask

    task automatic do_reset();
        drive(1'b0, 0, 0, 1'b0);
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        step();
    endtask

    int q[$];
    int ovf_m;
    int s;
    logic exp_rdy;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        drive(1'b0, 0, 0, 1'b0);
        #2;
        do_reset();

        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check_ovf("reset_ovf", 0);

        // Vector table: single push, observe, single pop.
        vecs[0] = '{4'd4,  4'd4,  5'd8};
        vecs[1] = '{4'd0,  4'd0,  5'd0};
        vecs[2] = '{4'd15, 4'd15, 5'd30};
        vecs[3] = '{4'd15, 4'd0,  5'd15};
        vecs[4] = '{4'd7,  4'd9,  5'd16};
        vecs[5] = '{4'd1,  4'd2,  5'd3};
        vecs[6] = '{4'd8,  4'd8,  5'd16};
        vecs[7] = '{4'd10, 4'd5,  5'd15};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, int'(vecs[i].va), int'(vecs[i].vb), 1'b0);
            #1;
            check("vec_out_valid_before", 32'(out_valid), 32'd0);
            step();
            drive(1'b0, 0, 0, 1'b0);
            #1;
            check("vec_out_valid", 32'(out_valid), 32'd1);
            check("vec_sum", 32'(sum), 32'(vecs[i].exp_sum));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            #1;
            check("vec_empty_after_pop", 32'(out_valid), 32'd0);
        end

        // Mid-cycle operand changes without handshake are ignored.
        drive(1'b1, 4, 4, 1'b0);
        step();
        in_valid = 1'b0;
        #1 a = 4'd3;
        #2 a = 4'd4;
        step();
        check("toggle_sum", 32'(sum), 32'd8);
        out_ready = 1'b1;
        step();
        check("toggle_single_result", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Fill and backpressure.
        drive(1'b1, 3, 4, 1'b0);
        step();
        drive(1'b1, 5, 6, 1'b0);
        step();
        drive(1'b1, 7, 8, 1'b0);
        #1;
        check("bp_in_ready_full", 32'(in_ready), 32'd0);
        step();
        check("bp_held_head", 32'(sum), 32'd7);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_with_pop", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_second", 32'(sum), 32'd11);
        step();
        check("bp_third", 32'(sum), 32'd15);
        step();
        check("bp_drained", 32'(out_valid), 32'd0);

        // Full with concurrent push/pop.
        drive(1'b1, 10, 0, 1'b0);
        step();
        drive(1'b1, 0, 11, 1'b0);
        step();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, i, i, 1'b1);
            #1;
            check("full_pp_in_ready", 32'(in_ready), 32'd1);
            s = (i == 1) ? 10 : (i == 2) ? 11 : 2 * (i - 2);
            check("full_pp_sum", 32'(sum), 32'(s));
            step();
        end
        in_valid = 1'b0;
        check("full_pp_tail0", 32'(sum), 32'd6);
        step();
        check("full_pp_tail1", 32'(sum), 32'd8);
        step();
        check("full_pp_empty", 32'(out_valid), 32'd0);

        // Asynchronous reset with two stored entries.
        drive(1'b1, 1, 2, 1'b0);
        step();
        drive(1'b1, 15, 15, 1'b0);
        step();
        in_valid = 1'b0;
        #2;
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(out_valid), 32'd0);
        check("async_reset_sum", 32'(sum), 32'd0);
        check("async_reset_in_ready", 32'(in_ready), 32'd1);
        check_ovf("async_reset_ovf", 0);
        #1 rst_n = 1'b1;
        step();
        check("post_reset_empty", 32'(out_valid), 32'd0);

        // Overflow sequence with saturation at 3.
        for (int i = 0; i < 5; i++) begin
            s = (i == 0) ? 15 : (i == 1) ? 8 : (i == 2) ? 1 : (i == 3) ? 9 : 12;
            drive(1'b1, s, s, 1'b1);
            step();
            check("ovf_seq_sum", 32'(sum), 32'(2 * s));
            check_ovf("ovf_seq_cnt", (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 2 : 3);
        end
        drive(1'b0, 0, 0, 1'b1);
        step();
        check("ovf_seq_empty", 32'(out_valid), 32'd0);

        // Randomized run against a queue model.
        do_reset();
        q.delete();
        ovf_m = 0;
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), ($urandom_range(0, 2) != 0));
            #1;
            exp_rdy = (q.size() < DEPTH) || out_ready;
            check("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
            check("rnd_out_valid", 32'(out_valid), 32'(q.size() != 0));
            check("rnd_sum", 32'(sum), 32'((q.size() != 0) ? q[0] : 0));
            check_ovf("rnd_ovf", ovf_m);
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (in_valid && exp_rdy) begin
                s = int'(a) + int'(b);
                q.push_back(s);
                if (s >= (1 << WIDTH) && ovf_m < OVF_MAX) ovf_m++;
            end
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
